// File: rtl/uart_rx_pkg.sv
// Shared UART receive-side types and helpers: deserializer state encoding,
// minimum frame width and the parity-bit calculation used by TX and scoreboards.
package uart_rx_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2,
      DONE   = 2'd3
   } rx_deser_state_e;

   localparam int MIN_DATA_W = 5;
   localparam int PAR_MAX_W  = 16;

   // Parity bit a transmitter appends so that data^parity has the requested sense.
   function automatic logic par_calc(
      input logic [PAR_MAX_W-1:0] data,
      input logic [4:0]           len,
      input logic                 odd
   );
      logic p;
      p = odd;
      for (int i = 0; i < PAR_MAX_W; i++) begin
         if (5'(i) < len) begin
            p = p ^ data[i];
         end else begin
            p = p;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/uart_rx_out_reg.sv
// Output holding register for the RX deserializer: parallel word, parity error,
// valid/ready handshake and sticky overrun flag.
module uart_rx_out_reg
   import uart_rx_pkg::*;
#(
   parameter int MAX_W = 9
) (
   input  logic             RX_clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [MAX_W-1:0] data_i,
   input  logic             perr_i,
   input  logic             p_ready_i,
   input  logic             ovr_clr_i,
   output logic [MAX_W-1:0] p_data_o,
   output logic             p_valid_o,
   output logic             par_err_o,
   output logic             overrun_o
);

   logic [MAX_W-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             perr_q, perr_d;
   logic             ovr_q, ovr_d;
   logic             ovr_evt_s;

   // Next-state for the handshake register; a load always wins over an acceptance.
   always_comb begin
      data_d    = data_q;
      perr_d    = perr_q;
      valid_d   = valid_q;
      ovr_d     = ovr_q;
      ovr_evt_s = load_i & valid_q & ~p_ready_i;

      if (load_i) begin
         data_d  = data_i;
         perr_d  = perr_i;
         valid_d = 1'b1;
      end else if (valid_q & p_ready_i) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end

      if (ovr_evt_s) begin
         ovr_d = 1'b1;
      end else if (ovr_clr_i) begin
         ovr_d = 1'b0;
      end else begin
         ovr_d = ovr_q;
      end
   end

   // Output state registers.
   always_ff @(posedge RX_clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         ovr_q   <= ovr_d;
      end
   end

   assign p_data_o  = data_q;
   assign p_valid_o = valid_q;
   assign par_err_o = perr_q;
   assign overrun_o = ovr_q;

endmodule

// File: rtl/uart_rx_deser_param.sv
// Parametrised UART receive deserializer: collects data_len bits in either bit
// order, checks parity and hands the word to the output handshake register.
module uart_rx_deser_param
   import uart_rx_pkg::*;
#(
   parameter int MAX_W     = 9,
   parameter int LSB_FIRST = 1,
   parameter int CNT_W     = $clog2(MAX_W + 1)
) (
   input  logic             RX_clk,
   input  logic             rst_n,
   input  logic             frame_start_i,
   input  logic             deser_en_i,
   input  logic             sampled_bit_i,
   input  logic [CNT_W-1:0] data_len_i,
   input  logic             par_en_i,
   input  logic             par_odd_i,
   input  logic             par_bit_en_i,
   output logic [MAX_W-1:0] p_data_o,
   output logic             p_valid_o,
   input  logic             p_ready_i,
   output logic             par_err_o,
   output logic             overrun_o,
   input  logic             ovr_clr_i,
   output logic             busy_o
);

   rx_deser_state_e  state_q, state_d;
   logic [MAX_W-1:0] shift_q, shift_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic             acc_q, acc_d;
   logic             par_en_q, par_en_d;
   logic             par_odd_q, par_odd_d;
   logic             perr_q, perr_d;
   logic             busy_q, busy_d;

   logic [CNT_W-1:0] len_clamp_s;
   logic [CNT_W-1:0] wr_idx_s;
   logic [MAX_W-1:0] mask_s;
   logic             load_s;

   // Frame length clamp, write index for the selected bit order and output mask.
   always_comb begin
      if ((data_len_i < CNT_W'(MIN_DATA_W)) || (data_len_i > CNT_W'(MAX_W))) begin
         len_clamp_s = CNT_W'(MAX_W);
      end else begin
         len_clamp_s = data_len_i;
      end

      if (LSB_FIRST != 0) begin
         wr_idx_s = cnt_q;
      end else begin
         wr_idx_s = len_q - cnt_q - CNT_W'(1);
      end

      for (int i = 0; i < MAX_W; i++) begin
         mask_s[i] = (CNT_W'(i) < len_q);
      end
      load_s = (state_q == DONE);
   end

   // FSM next state plus shift, count and parity accumulation; frame_start overrides all.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      acc_d     = acc_q;
      par_en_d  = par_en_q;
      par_odd_d = par_odd_q;
      perr_d    = perr_q;

      if (frame_start_i) begin
         state_d   = SHIFT;
         shift_d   = '0;
         cnt_d     = '0;
         acc_d     = 1'b0;
         perr_d    = 1'b0;
         len_d     = len_clamp_s;
         par_en_d  = par_en_i;
         par_odd_d = par_odd_i;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            SHIFT: begin
               if (deser_en_i && (cnt_q < len_q)) begin
                  for (int i = 0; i < MAX_W; i++) begin
                     if (CNT_W'(i) == wr_idx_s) begin
                        shift_d[i] = sampled_bit_i;
                     end else begin
                        shift_d[i] = shift_q[i];
                     end
                  end
                  cnt_d = cnt_q + CNT_W'(1);
                  acc_d = acc_q ^ sampled_bit_i;
                  if ((cnt_q + CNT_W'(1)) == len_q) begin
                     state_d = par_en_q ? PARITY : DONE;
                  end else begin
                     state_d = SHIFT;
                  end
               end else begin
                  state_d = SHIFT;
               end
            end
            PARITY: begin
               if (par_bit_en_i) begin
                  perr_d  = par_en_q & (acc_q ^ sampled_bit_i ^ par_odd_q);
                  state_d = DONE;
               end else begin
                  state_d = PARITY;
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      busy_d = (state_d == SHIFT) || (state_d == PARITY);
   end

   // Frame collection registers.
   always_ff @(posedge RX_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         cnt_q     <= '0;
         len_q     <= '0;
         acc_q     <= 1'b0;
         par_en_q  <= 1'b0;
         par_odd_q <= 1'b0;
         perr_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         acc_q     <= acc_d;
         par_en_q  <= par_en_d;
         par_odd_q <= par_odd_d;
         perr_q    <= perr_d;
         busy_q    <= busy_d;
      end
   end

   assign busy_o = busy_q;

   uart_rx_out_reg #(
      .MAX_W (MAX_W)
   ) u_out_reg (
      .RX_clk    (RX_clk),
      .rst_n     (rst_n),
      .load_i    (load_s),
      .data_i    (shift_q & mask_s),
      .perr_i    (perr_q),
      .p_ready_i (p_ready_i),
      .ovr_clr_i (ovr_clr_i),
      .p_data_o  (p_data_o),
      .p_valid_o (p_valid_o),
      .par_err_o (par_err_o),
      .overrun_o (overrun_o)
   );

endmodule

// File: tb/tb_uart_rx_deser_param.sv
// Self-checking bench: LSB-first and MSB-first instances share stimulus and are
// compared against a bit-list reference model of frames and the output handshake.
module tb_uart_rx_deser_param;

   localparam int MAX_W = 9;
   localparam int CNT_W = $clog2(MAX_W + 1);

   logic             RX_clk = 1'b0;
   logic             rst_n;
   logic             frame_start, deser_en, sampled_bit, par_en, par_odd, par_bit_en;
   logic [CNT_W-1:0] data_len;
   logic             p_ready, ovr_clr;
   logic [MAX_W-1:0] p_data_l, p_data_m;
   logic             p_valid_l, p_valid_m, par_err_l, par_err_m;
   logic             overrun_l, overrun_m, busy_l, busy_m;

   int n_checks = 0;
   int n_errors = 0;
   int rise_cnt = 0;
   logic pv_prev = 1'b0;

   logic [MAX_W-1:0] exp_l, exp_m;
   logic             exp_valid, exp_ovr, exp_perr;

   always #5 RX_clk = ~RX_clk;

   uart_rx_deser_param #(.MAX_W(MAX_W), .LSB_FIRST(1)) u_dut_lsb (
      .RX_clk(RX_clk), .rst_n(rst_n), .frame_start_i(frame_start), .deser_en_i(deser_en),
      .sampled_bit_i(sampled_bit), .data_len_i(data_len), .par_en_i(par_en),
      .par_odd_i(par_odd), .par_bit_en_i(par_bit_en), .p_data_o(p_data_l),
      .p_valid_o(p_valid_l), .p_ready_i(p_ready), .par_err_o(par_err_l),
      .overrun_o(overrun_l), .ovr_clr_i(ovr_clr), .busy_o(busy_l));

   uart_rx_deser_param #(.MAX_W(MAX_W), .LSB_FIRST(0)) u_dut_msb (
      .RX_clk(RX_clk), .rst_n(rst_n), .frame_start_i(frame_start), .deser_en_i(deser_en),
      .sampled_bit_i(sampled_bit), .data_len_i(data_len), .par_en_i(par_en),
      .par_odd_i(par_odd), .par_bit_en_i(par_bit_en), .p_data_o(p_data_m),
      .p_valid_o(p_valid_m), .p_ready_i(p_ready), .par_err_o(par_err_m),
      .overrun_o(overrun_m), .ovr_clr_i(ovr_clr), .busy_o(busy_m));

   // Count rising edges of p_valid on the LSB-first instance.
   always @(negedge RX_clk) begin
      if (p_valid_l && !pv_prev) rise_cnt <= rise_cnt + 1;
      pv_prev <= p_valid_l;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge RX_clk);
      #1;
   endtask

   function automatic int eff_len(input int len);
      return (len < 5 || len > MAX_W) ? MAX_W : len;
   endfunction

   function automatic logic [MAX_W-1:0] word_of(input logic [15:0] seq, input int len, input bit lsb);
      logic [MAX_W-1:0] w = '0;
      for (int i = 0; i < len; i++) begin
         if (lsb) w[i] = seq[i];
         else     w[len-1-i] = seq[i];
      end
      return w;
   endfunction

   function automatic logic perr_of(input logic [15:0] seq, input int len, input bit pen,
                                    input bit podd, input bit pb);
      int ones = 0;
      for (int i = 0; i < len; i++) ones += int'(seq[i]);
      return pen && (((ones + int'(pb)) % 2) != int'(podd));
   endfunction

   task automatic check_outputs(input string tag, input bit exp_busy);
      check_eq({tag, "_data_lsb"}, 32'(p_data_l), 32'(exp_l));
      check_eq({tag, "_data_msb"}, 32'(p_data_m), 32'(exp_m));
      check_eq({tag, "_valid_lsb"}, 32'(p_valid_l), 32'(exp_valid));
      check_eq({tag, "_valid_msb"}, 32'(p_valid_m), 32'(exp_valid));
      check_eq({tag, "_perr_lsb"}, 32'(par_err_l), 32'(exp_perr));
      check_eq({tag, "_perr_msb"}, 32'(par_err_m), 32'(exp_perr));
      check_eq({tag, "_ovr_lsb"}, 32'(overrun_l), 32'(exp_ovr));
      check_eq({tag, "_ovr_msb"}, 32'(overrun_m), 32'(exp_ovr));
      check_eq({tag, "_busy_lsb"}, 32'(busy_l), 32'(exp_busy));
      check_eq({tag, "_busy_msb"}, 32'(busy_m), 32'(exp_busy));
   endtask

   task automatic start_frame(input int len, input bit pen, input bit podd);
      frame_start = 1'b1;
      data_len    = CNT_W'(len);
      par_en      = pen;
      par_odd     = podd;
      tick();
      frame_start = 1'b0;
      data_len    = CNT_W'($urandom_range(0, 15));
      par_en      = 1'($urandom_range(0, 1));
      par_odd     = 1'($urandom_range(0, 1));
   endtask

   task automatic strobe(input bit b, input bit noise);
      repeat ($urandom_range(0, 2)) begin
         sampled_bit = 1'($urandom_range(0, 1));
         par_bit_en  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         tick();
         par_bit_en  = 1'b0;
      end
      deser_en    = 1'b1;
      sampled_bit = b;
      tick();
      deser_en    = 1'b0;
   endtask

   task automatic send_frame(input int len, input bit pen, input bit podd, input logic [15:0] seq,
                             input bit pb, input bit rdy, input bit clr);
      int el;
      el = eff_len(len);
      start_frame(len, pen, podd);
      check_eq("busy_in_frame", 32'(busy_l), 32'd1);
      for (int i = 0; i < el; i++) strobe(seq[i], 1'b1);
      if (pen) begin
         repeat ($urandom_range(0, 2)) tick();
         par_bit_en  = 1'b1;
         sampled_bit = pb;
         tick();
         par_bit_en  = 1'b0;
      end
      check_eq("busy_after_last", 32'(busy_l), 32'd0);
      check_eq("valid_before_load", 32'(p_valid_l), 32'(exp_valid));
      p_ready     = rdy;
      ovr_clr     = clr;
      deser_en    = 1'b1;
      par_bit_en  = 1'b1;
      sampled_bit = 1'($urandom_range(0, 1));
      tick();
      p_ready     = 1'b0;
      ovr_clr     = 1'b0;
      deser_en    = 1'b0;
      par_bit_en  = 1'b0;
      if (exp_valid && !rdy) exp_ovr = 1'b1;
      else if (clr)          exp_ovr = 1'b0;
      exp_valid = 1'b1;
      exp_l     = word_of(seq, el, 1'b1);
      exp_m     = word_of(seq, el, 1'b0);
      exp_perr  = perr_of(seq, el, pen, podd, pb);
      check_outputs("frame", 1'b0);
   endtask

   task automatic handshake(input bit rdy, input bit clr);
      p_ready = rdy;
      ovr_clr = clr;
      tick();
      p_ready = 1'b0;
      ovr_clr = 1'b0;
      if (exp_valid && rdy) exp_valid = 1'b0;
      if (clr) exp_ovr = 1'b0;
      check_outputs("handshake", 1'b0);
   endtask

   task automatic model_reset();
      exp_l = '0; exp_m = '0; exp_valid = 1'b0; exp_ovr = 1'b0; exp_perr = 1'b0;
   endtask

   initial begin
      int rise0;
      rst_n = 1'b0; frame_start = 1'b0; deser_en = 1'b0; sampled_bit = 1'b0;
      data_len = '0; par_en = 1'b0; par_odd = 1'b0; par_bit_en = 1'b0;
      p_ready = 1'b0; ovr_clr = 1'b0;
      model_reset();
      #12;
      check_outputs("reset", 1'b0);
      rst_n = 1'b1;
      tick();

      // LSB-first word 0x04D, MSB-first 0x013
      send_frame(8, 1'b0, 1'b0, 16'h004D, 1'b0, 1'b0, 1'b0);
      check_eq("tp1_const", 32'(p_data_l), 32'h04D);
      handshake(1'b1, 1'b0);
      send_frame(5, 1'b0, 1'b0, 16'h0019, 1'b0, 1'b0, 1'b0);
      check_eq("tp2_const", 32'(p_data_m), 32'h013);
      handshake(1'b1, 1'b0);

      // Parity cases on 0x55 with len 7
      send_frame(7, 1'b1, 1'b0, 16'h0055, 1'b1, 1'b0, 1'b0);
      check_eq("par_even_pb1", 32'(par_err_l), 32'd1);
      handshake(1'b1, 1'b0);
      send_frame(7, 1'b1, 1'b0, 16'h0055, 1'b0, 1'b0, 1'b0);
      check_eq("par_even_pb0", 32'(par_err_l), 32'd0);
      handshake(1'b1, 1'b0);
      send_frame(7, 1'b1, 1'b1, 16'h0055, 1'b1, 1'b0, 1'b0);
      check_eq("par_odd_pb1", 32'(par_err_l), 32'd0);
      handshake(1'b1, 1'b0);

      // Back-to-back frames without acceptance, then clear + accept together
      send_frame(8, 1'b0, 1'b0, 16'h00A5, 1'b0, 1'b0, 1'b0);
      send_frame(8, 1'b0, 1'b0, 16'h003C, 1'b0, 1'b0, 1'b0);
      check_eq("b2b_data", 32'(p_data_l), 32'h03C);
      check_eq("b2b_ovr", 32'(overrun_l), 32'd1);
      handshake(1'b1, 1'b1);
      check_eq("b2b_clr_ovr", 32'(overrun_l), 32'd0);
      check_eq("b2b_valid_fall", 32'(p_valid_l), 32'd0);

      // Mid-frame abort followed by a full frame
      rise0 = rise_cnt;
      start_frame(8, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) strobe(1'b1, 1'b0);
      send_frame(8, 1'b0, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0);
      check_eq("abort_data", 32'(p_data_l), 32'h0FF);
      handshake(1'b1, 1'b0);
      check_eq("abort_pulses", 32'(rise_cnt - rise0), 32'd1);
      start_frame(9, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) strobe(1'b1, 1'b0);
      send_frame(5, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      check_eq("abort_short_data", 32'(p_data_m), 32'h000);
      handshake(1'b1, 1'b0);

      // Randomised frames, lengths (incl. out-of-range), parity and handshake timing
      for (int k = 0; k < 40; k++) begin
         int len;
         len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(5, 9));
         send_frame(len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) handshake(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      // Asynchronous reset in the middle of a frame with valid and overrun set
      send_frame(8, 1'b0, 1'b0, 16'h0012, 1'b0, 1'b0, 1'b0);
      send_frame(8, 1'b0, 1'b0, 16'h0034, 1'b0, 1'b0, 1'b0);
      start_frame(8, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) strobe(1'b1, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("async_reset", 1'b0);
      #2;
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) strobe(1'b1, 1'b0);
      check_outputs("no_capture", 1'b0);
      send_frame(6, 1'b1, 1'b1, 16'h002B, 1'b0, 1'b0, 1'b0);
      handshake(1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_deser_param.md
Name: uart_rx_deser_param

Overview:
- Parametrised UART receive deserializer.
- Sits between the RX bit-sampler/edge-counter and the RX frame FSM, which supplies per-bit enables and frame control.
- Assembles a configurable number of data bits (LSB- or MSB-first), computes running parity and delivers the word on a valid/ready handshake with overrun detection.
- Replaces the fixed 8-bit, always-LSB-first deserializer.

Parameters:
- MAX_W, 9: maximum data bits per frame; legal 5..16.
- LSB_FIRST, 1: 1 = first received bit lands in bit 0; 0 = first received bit lands in bit (data_len-1).
- CNT_W, $clog2(MAX_W+1): bit-counter width (derived, not overridden).

Ports:
- RX_clk  in  1  receive clock
- rst_n  in  1  async active-low reset
- frame_start  in  1  one-cycle pulse from frame FSM at start-bit confirm; clears shift state
- deser_en  in  1  one-cycle strobe: sampled_bit is valid this cycle
- sampled_bit  in  1  majority-voted data bit
- data_len  in  CNT_W  data bits per frame (5..MAX_W), sampled at frame_start
- par_en  in  1  parity enabled (sampled at frame_start)
- par_odd  in  1  1 = odd parity, 0 = even (sampled at frame_start)
- par_bit_en  in  1  strobe: sampled_bit is the parity bit
- p_data  out  MAX_W  received word, zero-extended above data_len
- p_valid  out  1  p_data holds an unread word
- p_ready  in  1  consumer accepts p_data when p_valid & p_ready
- par_err  out  1  parity mismatch for the word in p_data
- overrun  out  1  sticky: a word completed while p_valid was high and unaccepted
- ovr_clr  in  1  clears overrun
- busy  out  1  frame bits still being collected

Behaviour:
- Reset (async, rst_n low):
  - p_data = 0, p_valid = 0, par_err = 0, overrun = 0, busy = 0.
  - Shift register, counter and parity accumulator are 0.
  - State = IDLE.
- State machine:
  - IDLE: go to SHIFT on frame_start.
  - SHIFT: go to PARITY on the strobe that captures bit data_len if the latched par_en = 1, else to DONE.
  - PARITY: go to DONE on par_bit_en.
  - DONE: one cycle; go to IDLE.
- frame_start:
  - Accepted in any state, including mid-frame. A mid-frame frame_start aborts the frame: the partial word is discarded, p_valid and overrun are unchanged, and the state goes to SHIFT.
  - Latches data_len, par_en and par_odd. A data_len outside 5..MAX_W is clamped to MAX_W.
- SHIFT, per deser_en:
  - Write sampled_bit at index cnt when LSB_FIRST = 1, else at index len-1-cnt.
  - cnt += 1; acc ^= sampled_bit.
  - deser_en outside SHIFT is ignored. Extra strobes after the count completes are ignored.
- PARITY: on par_bit_en, perr = par_en & (acc ^ sampled_bit ^ par_odd).
  - Even parity requires the XOR of data and parity bits to be 0; odd requires 1.
  - par_bit_en outside PARITY is ignored.
- DONE, the output load:
  - In the same cycle: p_data <= shift reg with bits at index ≥ len forced to 0; par_err <= perr; p_valid <= 1.
  - Latency: p_valid is high 1 cycle after the final strobe's clock edge.
  - If p_valid = 1 and p_ready = 0 in that cycle, p_data and par_err are still overwritten with the new word and overrun <= 1.
- Handshake:
  - p_valid falls the cycle after p_valid & p_ready.
  - If a DONE load coincides with an acceptance, the new word loads, p_valid stays 1 and no overrun is flagged.
  - p_data is stable while p_valid = 1 and no load occurs.
- overrun:
  - Cleared by ovr_clr.
  - If ovr_clr coincides with a new overrun event, set wins.
- busy = (state == SHIFT) | (state == PARITY).
- Width rules:
  - Counter saturates at len.
  - No X on p_data bits above len.
  - All outputs are registered.

Decomposition:
- Package uart_rx_pkg holds:
  - typedef rx_deser_state_e {IDLE, SHIFT, PARITY, DONE}
  - MIN_DATA_W = 5
  - function par_calc(data, len, odd), shared with the TX serializer and the scoreboard
- One sub-module is natural: uart_rx_out_reg (p_data/p_valid/par_err/overrun handshake register).
- The shift/count/FSM stays in the top level.

Test Plan:
- MAX_W=9, LSB_FIRST=1, len=8, par_en=0, bits 1,0,1,1,0,0,1,0 -> p_data=0x04D, p_valid high 1 cycle after the 8th strobe, par_err=0.
- LSB_FIRST=0, len=5, bits 1,0,0,1,1 -> p_data=0x013.
- len=7, even parity, data 0x55 (4 ones), parity bit 1 -> par_err=1. Repeat with parity bit 0 -> par_err=0. With par_odd=1, parity bit 1 -> par_err=0.
- Two back-to-back frames 0xA5 then 0x3C with p_ready held 0 -> p_data=0x3C, overrun=1. Then assert ovr_clr with ovr_clr and p_ready high together -> overrun=0, then p_valid=0 the next cycle.
- frame_start after 4 strobes of a len=8 frame, then a full frame 0xFF -> p_data=0x0FF, no stale bits, exactly one p_valid pulse.
- rst_n low mid-SHIFT (asynchronous, between clock edges) -> all outputs 0 immediately. After release, deser_en without frame_start -> no capture, busy=0.
